qracc_host_seq: RTL and testbench

Synthesizable host sequencer that drives one `seq_acc` instance end to end: weight load into the QR SRAM, optional read-back check, analog settle wait, then a programmable number of MAC batches with result counting. It sits between the SoC-side streams and the `seq_acc` MAC and `sram_itf` ports. It replaces bench-only write/read/MAC tasks with parametrised hardware that supports partial row loads, back-to-back batches, outstanding-result tracking and a timeout.

---
 rtl/qracc_pkg.sv | 24 ++
 rtl/qracc_host_wdog.sv | 27 ++
 rtl/qracc_host_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_qracc_host_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types for the QR accelerator host sequencer.
// The VERIFY state only exists when QRACC_HOST_READBACK_EN is defined.
package qracc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
`ifdef QRACC_HOST_READBACK_EN
    ST_VERIFY = 3'd2,
`endif
    ST_SETTLE = 3'd3,
    ST_MAC    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } host_state_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_TIMEOUT      = 2'd1,
    ERR_EXTRA_RESULT = 2'd2,
    ERR_READBACK     = 2'd3
  } host_err_t;

endpackage

// File: rtl/qracc_host_wdog.sv
// qracc_host_wdog: idle-cycle watchdog. Counts enabled cycles since the last
// clear and flags timeout once the count reaches the limit.
module qracc_host_wdog #(
  parameter int unsigned limit = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned cnt_w = $clog2(limit + 1);

  logic [cnt_w-1:0] cnt;

  // Idle counter; saturates at the limit until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !timeout)
      cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == cnt_w'(limit));

endmodule

// File: rtl/qracc_host_seq.sv
// qracc_host_seq: host sequencer driving one seq_acc instance: weight load into
// the QR SRAM, optional read-back check (QRACC_HOST_READBACK_EN), settle wait,
// then MAC batches with result counting and a watchdog.
module qracc_host_seq
  import qracc_pkg::*;
#(
  parameter int unsigned numRows       = 128,
  parameter int unsigned numCols       = 32,
  parameter int unsigned xBits         = 5,
  parameter int unsigned maxBatches    = 1024,
  parameter int unsigned settleCycles  = 5,
  parameter int unsigned timeoutCycles = 50000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [$clog2(numRows+1)-1:0]         row_count_i,
  input  logic [$clog2(maxBatches+1)-1:0]      batch_count_i,
  input  logic                                 w_valid_i,
  output logic                                 w_ready_o,
  input  logic [numCols-1:0]                   w_data_i,
  input  logic                                 x_valid_i,
  output logic                                 x_ready_o,
  input  logic [numRows*xBits-1:0]             x_data_i,
  output logic                                 rq_valid_o,
  output logic                                 rq_wr_o,
  input  logic                                 rq_ready_i,
  output logic [$clog2(numRows)-1:0]           addr_o,
  output logic [numCols-1:0]                   wr_data_o,
  input  logic                                 rd_valid_i,
  input  logic [numCols-1:0]                   rd_data_i,
  output logic                                 mac_valid_o,
  output logic [numRows*xBits-1:0]             mac_data_o,
  input  logic                                 mac_ready_i,
  input  logic                                 res_valid_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic [1:0]                           err_code_o,
  output logic [$clog2(maxBatches+1)-1:0]      res_count_o
);

  localparam int unsigned rw = $clog2(numRows + 1);
  localparam int unsigned aw = $clog2(numRows);
  localparam int unsigned bw = $clog2(maxBatches + 1);
  localparam int unsigned sw = $clog2(settleCycles + 1);

  host_state_t state, next_state;

  logic [rw-1:0]      row_cnt, idx;
  logic [bw-1:0]      batch_cnt, issued;
  logic [sw-1:0]      settle_cnt;
  logic [numCols-1:0] wchk;
  logic w_fire, rq_fire, x_fire, mac_fire;
  logic load_last, mac_last, drain_done, extra_res;
  logic wdog_clr, wdog_en, timeout, rd_take;

  assign w_fire   = w_valid_i && w_ready_o;
  assign rq_fire  = rq_valid_o && rq_ready_i;
  assign x_fire   = x_valid_i && x_ready_o;
  assign mac_fire = mac_valid_o && mac_ready_i;

  assign w_ready_o = (state == ST_LOAD) && !rq_valid_o && (idx < row_cnt);
  assign x_ready_o = (state == ST_MAC) && !mac_valid_o && (issued < batch_cnt);
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);

  assign load_last  = rq_fire && (idx == row_cnt);
  assign mac_last   = (mac_fire && (issued + 1'b1 == batch_cnt)) ||
                      (!mac_valid_o && (issued == batch_cnt));
  // Finishing on the strobe itself gives done_o one cycle after the last result.
  assign drain_done = (res_count_o == issued) ||
                      (res_valid_i && (res_count_o + 1'b1 == issued));
  // A result in the same cycle as a MAC handshake may belong to that request.
  assign extra_res  = res_valid_i && (state != ST_IDLE) &&
                      (mac_fire ? (res_count_o > issued) : (res_count_o >= issued));

`ifdef QRACC_HOST_READBACK_EN
  logic [numCols-1:0] rchk;
  logic rd_wait, rd_issue, verify_done;
  assign rd_take     = rd_valid_i && rd_wait;
  assign rd_issue    = (state == ST_VERIFY) && !rq_valid_o && !rd_wait && (idx < row_cnt);
  assign verify_done = !rq_valid_o && !rd_wait && (idx == row_cnt);
`else
  logic unused_rd;
  assign unused_rd = ^{rd_valid_i, rd_data_i};
  assign rd_take   = 1'b0;
`endif

  assign wdog_en  = (state != ST_IDLE) && (state != ST_DONE);
  assign wdog_clr = w_fire || rq_fire || x_fire || mac_fire || rd_take ||
                    res_valid_i || (next_state != state);

  qracc_host_wdog #(.limit(timeoutCycles)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a watchdog expiry overrides every active state.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_i) next_state = (row_count_i == '0) ? ST_SETTLE : ST_LOAD;
`ifdef QRACC_HOST_READBACK_EN
      ST_LOAD:   if (load_last) next_state = ST_VERIFY;
      ST_VERIFY: if (verify_done) next_state = ST_SETTLE;
`else
      ST_LOAD:   if (load_last) next_state = ST_SETTLE;
`endif
      ST_SETTLE: if (settle_cnt == sw'(settleCycles - 1)) next_state = ST_MAC;
      ST_MAC:    if (mac_last) next_state = ST_DRAIN;
      ST_DRAIN:  if (drain_done) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    if (timeout && wdog_en) next_state = ST_DONE;
  end

  // Run parameters, result counter and sticky error status.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      batch_cnt   <= '0;
      res_count_o <= '0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else if (state == ST_IDLE) begin
      if (start_i) begin
        row_cnt     <= row_count_i;
        batch_cnt   <= batch_count_i;
        res_count_o <= '0;
        err_o       <= 1'b0;
        err_code_o  <= ERR_NONE;
      end
    end else begin
      if (res_valid_i) res_count_o <= res_count_o + 1'b1;
      if (extra_res) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_EXTRA_RESULT;
      end
`ifdef QRACC_HOST_READBACK_EN
      if ((state == ST_VERIFY) && verify_done && (rchk != wchk)) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_READBACK;
      end
`endif
      if (timeout) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_TIMEOUT;
      end
    end
  end

  // SRAM request channel: one outstanding write (LOAD) or read (VERIFY).
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_valid_o <= 1'b0;
      rq_wr_o    <= 1'b0;
      addr_o     <= '0;
      wr_data_o  <= '0;
      idx        <= '0;
      wchk       <= '0;
`ifdef QRACC_HOST_READBACK_EN
      rchk       <= '0;
      rd_wait    <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      idx <= '0;
      if (start_i) wchk <= '0;
`ifdef QRACC_HOST_READBACK_EN
      rd_wait <= 1'b0;
      if (start_i) rchk <= '0;
`endif
    end else begin
      if (rq_fire) rq_valid_o <= 1'b0;
      if (w_fire) begin
        rq_valid_o <= 1'b1;
        rq_wr_o    <= 1'b1;
        addr_o     <= idx[aw-1:0];
        wr_data_o  <= w_data_i;
        wchk       <= wchk ^ w_data_i;
        idx        <= idx + 1'b1;
      end
`ifdef QRACC_HOST_READBACK_EN
      if ((state == ST_LOAD) && load_last) idx <= '0;
      if (rq_fire && !rq_wr_o) rd_wait <= 1'b1;
      if (rd_take) begin
        rchk    <= rchk ^ rd_data_i;
        rd_wait <= 1'b0;
      end
      if (rd_issue) begin
        rq_valid_o <= 1'b1;
        rq_wr_o    <= 1'b0;
        addr_o     <= idx[aw-1:0];
        idx        <= idx + 1'b1;
      end
`endif
      // A watchdog abort is the only non-reset way a pending request drops.
      if (timeout) rq_valid_o <= 1'b0;
    end
  end

  // MAC request channel and issued-batch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_valid_o <= 1'b0;
      mac_data_o  <= '0;
      issued      <= '0;
    end else if (state == ST_IDLE) begin
      issued <= '0;
    end else begin
      if (mac_fire) begin
        mac_valid_o <= 1'b0;
        issued      <= issued + 1'b1;
      end
      if (x_fire) begin
        mac_valid_o <= 1'b1;
        mac_data_o  <= x_data_i;
      end
      if (timeout) mac_valid_o <= 1'b0;
    end
  end

  // Settle delay counter, running only while in SETTLE.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_SETTLE)) settle_cnt <= '0;
    else                             settle_cnt <= settle_cnt + 1'b1;
  end

endmodule

// File: tb/tb_qracc_host_seq.sv
// tb_qracc_host_seq: directed, scoreboarded bench for qracc_host_seq with an
// SRAM model, a MAC result model and a stalling request responder.
module tb_qracc_host_seq;

  localparam int unsigned NR = 128;
  localparam int unsigned NC = 32;
  localparam int unsigned XB = 5;
  localparam int unsigned MB = 16;
  localparam int unsigned SC = 5;
  localparam int unsigned TO = 200;
  localparam int unsigned RW = $clog2(NR + 1);
  localparam int unsigned AW = $clog2(NR);
  localparam int unsigned BW = $clog2(MB + 1);
  localparam int unsigned XW = NR * XB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [RW-1:0] row_count_i = '0;
  logic [BW-1:0] batch_count_i = '0;
  logic          w_valid_i = 1'b0;
  logic          w_ready_o;
  logic [NC-1:0] w_data_i = '0;
  logic          x_valid_i = 1'b0;
  logic          x_ready_o;
  logic [XW-1:0] x_data_i = '0;
  logic          rq_valid_o, rq_wr_o;
  logic          rq_ready_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic [NC-1:0] wr_data_o;
  logic          rd_valid_i = 1'b0;
  logic [NC-1:0] rd_data_i = '0;
  logic          mac_valid_o;
  logic [XW-1:0] mac_data_o;
  logic          mac_ready_i = 1'b1;
  logic          res_valid_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [1:0]    err_code_o;
  logic [BW-1:0] res_count_o;

  qracc_host_seq #(
    .numRows(NR), .numCols(NC), .xBits(XB), .maxBatches(MB),
    .settleCycles(SC), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .row_count_i(row_count_i),
    .batch_count_i(batch_count_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .w_data_i(w_data_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .x_data_i(x_data_i), .rq_valid_o(rq_valid_o), .rq_wr_o(rq_wr_o),
    .rq_ready_i(rq_ready_i), .addr_o(addr_o), .wr_data_o(wr_data_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i), .mac_valid_o(mac_valid_o),
    .mac_data_o(mac_data_o), .mac_ready_i(mac_ready_i), .res_valid_i(res_valid_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .res_count_o(res_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW+NC-1:0] wq[$];
  logic [XW-1:0]    xq[$];
  int               res_at[$];
  logic [NC-1:0]    mem [NR];

  int  rq_stall = 0, stall_seen = 0, res_budget = 0;
  int  wr_count = 0, mac_count = 0, last_wr_cyc = 0, last_res_cyc = 0;
  logic flip_row2 = 1'b0;
  logic hold = 1'b0, rd_pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [NC-1:0] hold_data, rd_val;

  task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: SRAM responder/model and MAC result generator, acting at negedge.
  always @(negedge clk) begin
    logic [AW+NC-1:0] e;
    rd_valid_i  = 1'b0;
    res_valid_i = 1'b0;
    if (rst) begin
      rq_ready_i = 1'b0;
      stall_seen = 0;
      hold       = 1'b0;
      rd_pend    = 1'b0;
      res_at.delete();
    end else begin
      if (rd_pend) begin
        rd_valid_i = 1'b1;
        rd_data_i  = rd_val;
        rd_pend    = 1'b0;
      end
      if (hold) begin
        check("rq_hold_valid", rq_valid_o, 1);
        check("rq_hold_addr", addr_o, hold_addr);
        check("rq_hold_data", wr_data_o, hold_data);
        hold = 1'b0;
      end
      if (!rq_valid_o) begin
        rq_ready_i = 1'b0;
        stall_seen = 0;
      end else if (stall_seen >= rq_stall) begin
        rq_ready_i = 1'b1;
        stall_seen = 0;
        if (rq_wr_o) begin
          check("wr_expected", 32'(wq.size() != 0), 1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            check("wr_addr", addr_o, e[AW+NC-1:NC]);
            check("wr_data", wr_data_o, e[NC-1:0]);
          end
          mem[addr_o] = (flip_row2 && addr_o == AW'(2)) ? (wr_data_o ^ NC'(1)) : wr_data_o;
          wr_count++;
          last_wr_cyc = cyc;
        end else begin
          rd_pend = 1'b1;
          rd_val  = mem[addr_o];
        end
      end else begin
        rq_ready_i = 1'b0;
        stall_seen++;
        hold      = 1'b1;
        hold_addr = addr_o;
        hold_data = wr_data_o;
      end
      if (mac_valid_o && mac_ready_i) begin
        check("mac_expected", 32'(xq.size() != 0), 1);
        if (xq.size() != 0) check("mac_data", mac_data_o, xq.pop_front());
        mac_count++;
        if (res_budget > 0) begin
          res_budget--;
          res_at.push_back(cyc + 3);
        end
      end
      if (res_at.size() != 0 && res_at[0] == cyc) begin
        res_valid_i = 1'b1;
        void'(res_at.pop_front());
        last_res_cyc = cyc;
      end
    end
  end

  task automatic start_run(input int rows, input int batches);
    row_count_i   = RW'(rows);
    batch_count_i = BW'(batches);
    start_i       = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic send_w(input int a, input logic [NC-1:0] d);
    int n = 0;
    wq.push_back({AW'(a), d});
    w_valid_i = 1'b1;
    w_data_i  = d;
    do begin @(negedge clk); n++; end while (!w_ready_o && n < 1000);
    check("w_handshake_wait", w_ready_o, 1);
    @(posedge clk);
    #1 w_valid_i = 1'b0;
  endtask

  task automatic send_x(input logic [XW-1:0] d);
    int n = 0;
    xq.push_back(d);
    x_valid_i = 1'b1;
    x_data_i  = d;
    do begin @(negedge clk); n++; end while (!x_ready_o && n < 1000);
    check("x_handshake_wait", x_ready_o, 1);
    @(posedge clk);
    #1 x_valid_i = 1'b0;
  endtask

  task automatic rand_x(output logic [XW-1:0] d);
    for (int k = 0; k < int'(XW / 32); k++) d[k*32 +: 32] = $urandom;
  endtask

  task automatic wait_done(input int bound, output int at);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_o && n < bound);
    check("done_seen", done_o, 1);
    at = cyc;
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, busy_o, 0);
    check({p, "_done"}, done_o, 0);
    check({p, "_err"}, err_o, 0);
    check({p, "_err_code"}, err_code_o, 0);
    check({p, "_res_count"}, res_count_o, 0);
    check({p, "_rq_valid"}, rq_valid_o, 0);
    check({p, "_rq_wr"}, rq_wr_o, 0);
    check({p, "_mac_valid"}, mac_valid_o, 0);
    check({p, "_w_ready"}, w_ready_o, 0);
    check({p, "_x_ready"}, x_ready_o, 0);
    check({p, "_addr"}, addr_o, 0);
    check({p, "_wr_data"}, wr_data_o, 0);
    check({p, "_mac_data"}, mac_data_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed cycle %0d expected completion", cyc);
    $fatal(1, "bench stopped by global time limit");
  end

  initial begin
    int dc, wc0, mc0;
    logic [XW-1:0] xd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Four rows, no stall, zero batches.
    rq_stall = 0;
    wc0 = wr_count;
    start_run(4, 0);
    for (int i = 0; i < 4; i++) send_w(i, NC'(1) << i);
    wait_done(1000, dc);
    check("t1_writes", wr_count - wc0, 4);
`ifndef QRACC_HOST_READBACK_EN
    check("t1_settle_drain_latency", dc, last_wr_cyc + 8);
`endif
    check("t1_res_count", res_count_o, 0);
    check("t1_err", err_o, 0);

    // Three rows with two stall cycles per request.
    rq_stall = 2;
    wc0 = wr_count;
    start_run(3, 0);
    for (int i = 0; i < 3; i++) send_w(i, $urandom);
    wait_done(1000, dc);
    check("t2_writes", wr_count - wc0, 3);
    check("t2_err", err_o, 0);

    // No load, ten batches, results three cycles after each request.
    rq_stall   = 0;
    res_budget = 10;
    mc0 = mac_count;
    start_run(0, 10);
    for (int i = 0; i < 10; i++) begin
      rand_x(xd);
      send_x(xd);
    end
    wait_done(1000, dc);
    check("t3_mac_handshakes", mac_count - mc0, 10);
    check("t3_res_count", res_count_o, 10);
    check("t3_err", err_o, 0);
    check("t3_err_code", err_code_o, 0);
    check("t3_done_latency", dc, last_res_cyc + 1);

`ifdef QRACC_HOST_READBACK_EN
    // Read-back with a corrupted row 2.
    flip_row2  = 1'b1;
    res_budget = 2;
    start_run(4, 2);
    for (int i = 0; i < 4; i++) send_w(i, $urandom);
    for (int i = 0; i < 2; i++) begin
      rand_x(xd);
      send_x(xd);
    end
    wait_done(1000, dc);
    check("rb_err", err_o, 1);
    check("rb_err_code", err_code_o, 3);
    check("rb_res_count", res_count_o, 2);
    flip_row2 = 1'b0;
`endif

    // Two batches, one result: watchdog ends the run.
    res_budget = 1;
    start_run(0, 2);
    for (int i = 0; i < 2; i++) begin
      rand_x(xd);
      send_x(xd);
    end
    wait_done(2000, dc);
    check("to_err", err_o, 1);
    check("to_err_code", err_code_o, 1);
    check("to_res_count", res_count_o, 1);

    // Reset in the middle of LOAD with a write request pending.
    rq_stall = 1000;
    wc0 = wr_count;
    start_run(3, 1);
    send_w(0, 32'hA5A5_0001);
    @(negedge clk);
    check("rst_pending_rq", rq_valid_o, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    check("rst_no_write", wr_count, wc0);
    wq.delete();

    // Clean run after the abort.
    rq_stall   = 0;
    res_budget = 1;
    wc0 = wr_count;
    start_run(2, 1);
    send_w(0, 32'h1234_5678);
    send_w(1, 32'h0F0F_F0F0);
    rand_x(xd);
    send_x(xd);
    wait_done(1000, dc);
    check("post_rst_writes", wr_count - wc0, 2);
    check("post_rst_res_count", res_count_o, 1);
    check("post_rst_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
